pixel_stream_source: RTL
========================

# pixel_stream_source

Frame-buffered pixel transmitter that drives the feature-extraction pipeline's input stream. A host loads one 8-bit greyscale frame into an internal RAM, then issues a launch pulse. The block emits a one-cycle start strobe, streams the frame in raster order with a programmable inter-pixel gap, and waits for the pipeline's done indication before reporting frame completion. It sits directly upstream of the feature extractor: its `start_signal`, `pixel_valid_out` and `pixel_out` connect to the extractor's start, pixel-valid and pixel inputs, and the extractor's final done feeds back into `frame_done_in`.

## Interface
- IMG_WIDTH, 32, pixels per row (3x3 conv yields 30x30)
- IMG_HEIGHT, 32, rows per frame
- PIXEL_W, 8, pixel width in bits
- DONE_TIMEOUT, 4096, maximum cycles to wait for `frame_done_in` after the last pixel
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  host frame-RAM write strobe
- wr_addr  in  $clog2(IMG_WIDTH*IMG_HEIGHT)  raster address, row*IMG_WIDTH+col
- wr_data  in  PIXEL_W  pixel to store
- launch  in  1  start streaming the stored frame
- gap_cfg  in  4  idle cycles inserted after each pixel; latched at launch
- frame_done_in  in  1  done pulse from downstream pipeline
- start_signal  out  1  one-cycle strobe preceding the first pixel
- pixel_valid_out  out  1  `pixel_out` valid this cycle
- pixel_out  out  PIXEL_W  streamed pixel
- busy  out  1  high from launch acceptance until return to IDLE
- frame_complete  out  1  one-cycle pulse when downstream done is received
- timeout_err  out  1  one-cycle pulse when DONE_TIMEOUT expires

## Operation
- FSM states: IDLE, START, STREAM, GAP, WAIT_DONE.
- **IDLE**
  - `launch`=1 latches `gap_cfg` into `gap_q`, clears the pixel counter and moves to START.
- **START**
  - Drives `start_signal`=1 for exactly one cycle.
  - Issues the RAM read of address 0.
  - Moves to STREAM.
- **STREAM**
  - Drives `pixel_valid_out`=1 with `pixel_out` equal to the registered RAM data for the current address.
  - Increments the counter and pre-issues the next read.
  - Moves to GAP if `gap_q`≠0. Otherwise stays in STREAM.
  - After pixel IMG_WIDTH*IMG_HEIGHT−1, moves to WAIT_DONE regardless of `gap_q`.
- **GAP**
  - Counts `gap_q` idle cycles with `pixel_valid_out`=0, then returns to STREAM.
- **WAIT_DONE**
  - `frame_done_in`=1 pulses `frame_complete` and moves to IDLE.
  - Reaching DONE_TIMEOUT cycles without done pulses `timeout_err` and moves to IDLE.
- **Host writes**
  - Accepted only in IDLE.
  - Writes while `busy`=1 are dropped.
  - Writes with `wr_addr` ≥ IMG_WIDTH*IMG_HEIGHT are dropped.
- **Ignored inputs**
  - `launch` while `busy`=1.
  - `frame_done_in` outside WAIT_DONE.
- **Simultaneous events**
  - `wr_en` and `launch` in the same IDLE cycle: the write commits first, so the launched frame includes it.
  - `frame_done_in` on the timeout cycle: done wins. `frame_complete`=1, `timeout_err`=0.
- **Pixel data**
  - Passes through unmodified.
  - RAM contents survive `launch` and are not cleared by reset.

## Timing
- **Reset values**
  - `start_signal`, `pixel_valid_out`, `busy`, `frame_complete`, `timeout_err` = 0.
  - `pixel_out` = 0.
  - FSM in IDLE.
- **Launch to start**
  - `launch` sampled at cycle L.
  - `start_signal` and `busy` are high in cycle L+1.
- **Pixel timing**
  - Pixel k is valid in cycle L+2+k*(gap_q+1).
  - RAM read latency is 1 cycle, hidden by the START cycle.
- **Frame length**
  - With gap 0: exactly 1024 consecutive valid cycles, L+2 through L+1025.
  - No gap is inserted after the last pixel.
- **Completion**
  - `frame_complete` goes high the cycle after `frame_done_in` is sampled in WAIT_DONE.
  - `busy` drops in that same cycle.
  - A new `launch` is accepted from that cycle onward.
- **Reset mid-operation**
  - Assertion clears all outputs asynchronously.
  - Deassertion returns to IDLE.
  - No partial frame resumes.
- **Outputs** are registered. No combinational path from any input to any output.

## Structure
- Shared package `npu_pkg` holds:
  - IMG_WIDTH/IMG_HEIGHT defaults;
  - PIXEL_W;
  - pixel typedef;
  - the `src_state_t` enum.
- Sub-module `pixel_frame_ram`:
  - single-port, synchronous-read, IMG_WIDTH*IMG_HEIGHT x PIXEL_W;
  - write and read are muxed on busy;
  - no reset on the array.
- Top level holds the FSM, pixel counter, gap counter, timeout counter and output registers.

## Test plan
- Load the ramp `mem[a]=a mod 256`, gap_cfg=0, launch; `frame_done_in` arrives 50 cycles after the last pixel.
  - `start_signal` is high only at L+1.
  - 1024 back-to-back valids with `pixel_out`=k mod 256.
  - `frame_complete` 1 cycle after done; `busy` is high for 1024+52 cycles.
- gap_cfg=2, then change `gap_cfg` mid-frame.
  - Valids every 3rd cycle throughout.
  - Pixel 1023 valid at L+3071.
- Pulse `launch` and issue `wr_en` to address 5 with 0xAA while busy.
  - Both are ignored: the stream is unchanged and a re-launch still emits the original value at address 5.
- Never assert `frame_done_in` with DONE_TIMEOUT=16.
  - `timeout_err` pulses once, 16 cycles into WAIT_DONE.
  - Returns to IDLE with `busy`=0.
- Assert `rst`=0 at pixel 300, release, then relaunch.
  - All outputs are 0 during reset.
  - The new frame starts again at pixel 0 with the RAM intact.
- Assert `frame_done_in` in the same cycle the timeout expires.
  - `frame_complete`=1 and `timeout_err`=0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared frame geometry, pixel type and source-FSM state encoding for the feature-extraction front end.
package npu_pkg;
  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;
  localparam int PIXEL_W        = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STREAM,
    ST_GAP,
    ST_WAIT_DONE
  } src_state_t;
endpackage

// File: rtl/pixel_frame_ram.sv
// Single-port frame store: host writes while idle, streamer reads while busy.
// Latency: 1-cycle synchronous read into a reset-cleared data register.
// Backpressure: none; writes while busy or out of range are silently dropped.
module pixel_frame_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     addr;
  logic              we;

  assign addr = busy ? rd_addr : wr_addr;
  assign we   = wr_en && !busy && (int'(wr_addr) < DEPTH);

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (busy && rd_en) begin
      rd_data <= mem[addr];
    end
  end
endmodule

// File: rtl/pixel_stream_source.sv
// Streams a host-loaded frame in raster order with a programmable inter-pixel gap.
// Latency: start strobe 1 cycle after launch, pixel k at launch+2+k*(gap+1).
// Backpressure: none; launch and writes are ignored while busy.
module pixel_stream_source #(
  parameter int  IMG_WIDTH    = npu_pkg::IMG_WIDTH_DEF,
  parameter int  IMG_HEIGHT   = npu_pkg::IMG_HEIGHT_DEF,
  parameter int  PIXEL_W      = npu_pkg::PIXEL_W,
  parameter int  DONE_TIMEOUT = 4096,
  localparam int NPIX         = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW           = $clog2(NPIX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               launch,
  input  logic [3:0]         gap_cfg,
  input  logic               frame_done_in,
  output logic               start_signal,
  output logic               pixel_valid_out,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               busy,
  output logic               frame_complete,
  output logic               timeout_err
);
  import npu_pkg::*;

  localparam int            TW       = $clog2(DONE_TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  src_state_t    state, state_nxt;
  logic [AW-1:0] pix_cnt;
  logic [3:0]    gap_q, gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          done_hit, tmo_hit, rd_en;
  logic [AW-1:0] rd_addr;

  // Status strobes are pure decodes of the state register.
  assign start_signal    = (state == ST_START);
  assign pixel_valid_out = (state == ST_STREAM);
  assign busy            = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (launch) state_nxt = ST_START;
      end
      ST_START: begin
        rd_en     = 1'b1;
        state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (pix_cnt == LAST_PIX) begin
          state_nxt = ST_WAIT_DONE;
        end else begin
          rd_en   = 1'b1;
          rd_addr = pix_cnt + 1'b1;
          if (gap_q != 4'd0) state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == gap_q - 4'd1) state_nxt = ST_STREAM;
      end
      ST_WAIT_DONE: begin
        // Done takes priority over an expiring timeout in the same cycle.
        if (frame_done_in) begin
          done_hit  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      pix_cnt        <= '0;
      gap_q          <= '0;
      gap_cnt        <= '0;
      tmo_cnt        <= '0;
      frame_complete <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_complete <= done_hit;
      timeout_err    <= tmo_hit;
      if (state == ST_IDLE && launch) begin
        gap_q   <= gap_cfg;
        pix_cnt <= '0;
      end
      if (state == ST_STREAM) begin
        pix_cnt <= pix_cnt + 1'b1;
        gap_cnt <= '0;
        tmo_cnt <= '0;
      end
      if (state == ST_GAP)       gap_cnt <= gap_cnt + 4'd1;
      if (state == ST_WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  pixel_frame_ram #(
    .DEPTH  (NPIX),
    .DATA_W (PIXEL_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (pixel_out)
  );
endmodule
